fb_flag_branch_unit: RTL and testbench
======================================

FB_FLAG_BRANCH_UNIT -- requirements
Module: fb_flag_branch_unit

Interface
REQ-001 SHALL have parameter MAX_PEND, default 3, giving the maximum number of outstanding flag-setting instructions (1..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port flag_we, input, 1, flag writeback strobe, same cycle as ALU flag write.
REQ-005 SHALL have port flag_nzcv, input, 4, written flags {N,Z,C,V}, valid with flag_we.
REQ-006 SHALL have port flag_pend_set, input, 1, a flag-setting instruction issued, writeback pending.
REQ-007 SHALL have port br_valid, input, 1, conditional branch request valid.
REQ-008 SHALL have port br_cond, input, 4, condition code of the request.
REQ-009 SHALL have port br_ready, output, 1, unit can accept a request.
REQ-010 SHALL have port res_valid, output, 1, branch resolution valid.
REQ-011 SHALL have port res_taken, output, 1, resolved condition result.
REQ-012 SHALL have port res_ready, input, 1, consumer accepts the resolution.
REQ-013 SHALL have port pend_cnt, output, 3, current outstanding flag-write count.
REQ-014 SHALL have port err_ovf, output, 1, sticky: pend_set seen at MAX_PEND.

Function
REQ-015 SHALL hold a shadow NZCV register loaded with flag_nzcv on every flag_we, regardless of state.
REQ-016 SHALL maintain pend_cnt as follows: +1 on flag_pend_set alone, -1 on flag_we alone, unchanged on both.
REQ-017 SHALL leave pend_cnt unchanged on flag_pend_set alone at MAX_PEND, and SHALL set err_ovf.
REQ-018 SHALL leave pend_cnt at 0 on flag_we alone at count 0; the flags are still captured.
REQ-019 SHALL define the effective count as next-cycle pend_cnt, and the effective flags as flag_nzcv when flag_we, else the shadow register.
REQ-020 SHALL evaluate conditions with these codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
REQ-021 SHALL also evaluate: 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
REQ-022 SHALL implement FSM states IDLE, WAIT and RESP; br_ready=1 only in IDLE; res_valid=1 only in RESP.
REQ-023 In IDLE, on br_valid, SHALL register br_cond.
REQ-024 In IDLE, on acceptance with effective count 0, SHALL register res_taken from the effective flags and go to RESP (1-cycle latency).
REQ-025 In IDLE, on acceptance with effective count nonzero, SHALL go to WAIT.
REQ-026 In WAIT, SHALL stay while the effective count is nonzero.
REQ-027 In WAIT, when the effective count reaches 0, SHALL register res_taken from the effective flags (forwarded flag_nzcv) and go to RESP.
REQ-028 In RESP, SHALL hold res_valid and res_taken stable until res_ready, then go to IDLE; no request is accepted in the same cycle.
REQ-029 SHALL keep counting flag_pend_set/flag_we in WAIT and RESP; a branch captures only the flags that are final at its resolution.

Reset
REQ-030 On rst_n low, SHALL immediately force state IDLE, pend_cnt 0, shadow NZCV 0000, res_taken 0, err_ovf 0, stored cond 0; hence br_ready=1 and res_valid=0.
REQ-031 Reset mid-WAIT or mid-RESP SHALL drop the in-flight branch with no resolution emitted.

Structure
REQ-032 SHALL place the condition-code constants (EQ..NV) and the FSM state encodings in shared package fb_pkg.
REQ-033 SHALL implement the REQ-020/021 decode as combinational sub-module fb_cond_eval (inputs cond, nzcv; output taken), instantiated once.

Verification
REQ-034 Scenario: pend_cnt=0, shadow 0100, br_cond=0 (EQ) -> res_valid the next cycle, res_taken=1.
REQ-035 Scenario: pend_set, then br_cond=1 (NE), then flag_we with nzcv 0000 two cycles later -> WAIT held; RESP the cycle after flag_we, taken=1.
REQ-036 Scenario: pend_cnt=1, and br_valid plus flag_we with nzcv 1001, br_cond=A (GE), in the same cycle -> forwarded; taken=1 one cycle later.
REQ-037 Scenario: MAX_PEND=3, four pend_set with no flag_we -> pend_cnt=3, err_ovf=1 and sticky until reset.
REQ-038 Scenario: RESP with res_ready low for 5 cycles -> res_valid and res_taken stable, br_ready=0; on res_ready high -> IDLE the next cycle.
REQ-039 Scenario: rst_n low during WAIT with pend_cnt=2 -> all outputs at reset values at once; no res_valid after release.

Source files
------------

// File: rtl/fb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : fb_pkg                                                   |
// | Purpose   : Shared condition codes and FSM state encodings for the   |
// |             flag/branch resolution unit.                             |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package fb_pkg;

  // Condition codes, ARM-style ordering
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions inside the {N,Z,C,V} vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Branch FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fb_state_e;

endpackage : fb_pkg
`default_nettype wire

// File: rtl/fb_cond_eval.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fb_cond_eval                                             |
// | Purpose   : Combinational decode of a 4-bit condition code against   |
// |             an NZCV flag vector.                                     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fb_cond_eval
  import fb_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = nzcv[FLAG_N];
  assign w_z = nzcv[FLAG_Z];
  assign w_c = nzcv[FLAG_C];
  assign w_v = nzcv[FLAG_V];

  // Map each condition code onto its flag expression
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = w_z;
      COND_NE: taken = ~w_z;
      COND_CS: taken = w_c;
      COND_CC: taken = ~w_c;
      COND_MI: taken = w_n;
      COND_PL: taken = ~w_n;
      COND_VS: taken = w_v;
      COND_VC: taken = ~w_v;
      COND_HI: taken = w_c & ~w_z;
      COND_LS: taken = ~w_c | w_z;
      COND_GE: taken = (w_n == w_v);
      COND_LT: taken = (w_n != w_v);
      COND_GT: taken = ~w_z & (w_n == w_v);
      COND_LE: taken = w_z | (w_n != w_v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule : fb_cond_eval
`default_nettype wire

// File: rtl/fb_flag_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : fb_flag_branch_unit                                      |
// | Purpose   : Tracks outstanding flag-setting instructions, shadows    |
// |             the NZCV flags and resolves conditional branches once    |
// |             the flags they depend on are final.                      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module fb_flag_branch_unit
  import fb_pkg::*;
#(
  parameter int MAX_PEND = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic [3:0] flag_nzcv,
  input  logic       flag_pend_set,
  input  logic       br_valid,
  input  logic [3:0] br_cond,
  output logic       br_ready,
  output logic       res_valid,
  output logic       res_taken,
  input  logic       res_ready,
  output logic [2:0] pend_cnt,
  output logic       err_ovf
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_PEND);

  fb_state_e  state_q, state_d;
  logic [2:0] pend_q,  pend_d;
  logic [3:0] nzcv_q;
  logic [3:0] cond_q,  cond_d;
  logic       taken_q, taken_d;
  logic       ovf_q,   ovf_d;

  logic [3:0] eff_nzcv;
  logic [3:0] eval_cond;
  logic       eval_taken;

  // Outstanding-write counter: saturates at both ends, overflow is sticky
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    case ({flag_pend_set, flag_we})
      2'b10: begin
        if (pend_q == MAX_CNT) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + 3'd1;
        end
      end
      2'b01: begin
        if (pend_q != 3'd0) begin
          pend_d = pend_q - 3'd1;
        end
      end
      default: pend_d = pend_q;
    endcase
  end

  // Flags written this cycle are forwarded ahead of the shadow copy
  assign eff_nzcv  = flag_we ? flag_nzcv : nzcv_q;

  // A fresh request is evaluated with its own code; a waiting one with the stored code
  assign eval_cond = (state_q == ST_IDLE) ? br_cond : cond_q;

  fb_cond_eval u_cond_eval (
    .cond  (eval_cond),
    .nzcv  (eff_nzcv),
    .taken (eval_taken)
  );

  // Branch FSM: next state and captured resolution
  always_comb begin
    state_d = state_q;
    cond_d  = cond_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          cond_d = br_cond;
          if (pend_d == 3'd0) begin
            taken_d = eval_taken;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (pend_d == 3'd0) begin
          taken_d = eval_taken;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, shadow flags and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= 3'd0;
      nzcv_q  <= 4'b0000;
      cond_q  <= 4'h0;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cond_q  <= cond_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      if (flag_we) begin
        nzcv_q <= flag_nzcv;
      end
    end
  end

  assign br_ready  = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign res_taken = taken_q;
  assign pend_cnt  = pend_q;
  assign err_ovf   = ovf_q;

endmodule : fb_flag_branch_unit
`default_nettype wire

// File: tb/tb_fb_flag_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_fb_flag_branch_unit                                   |
// | Purpose   : Directed self-checking bench for fb_flag_branch_unit     |
// |             with a queue of expected branch outcomes.                |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_fb_flag_branch_unit;

  logic       clk;
  logic       rst_n;
  logic       flag_we;
  logic [3:0] flag_nzcv;
  logic       flag_pend_set;
  logic       br_valid;
  logic [3:0] br_cond;
  logic       br_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic [2:0] pend_cnt;
  logic       err_ovf;

  int total = 0;
  int bad   = 0;
  logic exp_q[$];

  fb_flag_branch_unit #(.MAX_PEND(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flag_we       (flag_we),
    .flag_nzcv     (flag_nzcv),
    .flag_pend_set (flag_pend_set),
    .br_valid      (br_valid),
    .br_cond       (br_cond),
    .br_ready      (br_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_ready     (res_ready),
    .pend_cnt      (pend_cnt),
    .err_ovf       (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference condition table written from the architectural definition
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a branch for one cycle and record its expected outcome
  task automatic issue(input logic [3:0] c, input logic [3:0] final_flags);
    exp_q.push_back(model(c, final_flags));
    br_valid = 1'b1;
    br_cond  = c;
    tick();
    br_valid = 1'b0;
  endtask

  // Check the pending resolution against the scoreboard and consume it
  task automatic resolve(input string tag);
    logic e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    chk({tag, "_valid"}, {7'd0, res_valid}, 8'd1);
    chk({tag, "_taken"}, {7'd0, res_taken}, {7'd0, e});
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_done"}, {6'd0, res_valid, br_ready}, 8'b01);
  endtask

  initial begin
    rst_n = 1'b1; flag_we = 1'b0; flag_nzcv = 4'h0; flag_pend_set = 1'b0;
    br_valid = 1'b0; br_cond = 4'h0; res_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_ready", {7'd0, br_ready}, 8'd1);
    chk("rst_valid", {7'd0, res_valid}, 8'd0);
    chk("rst_taken", {7'd0, res_taken}, 8'd0);
    chk("rst_pend",  {5'd0, pend_cnt}, 8'd0);
    chk("rst_ovf",   {7'd0, err_ovf}, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Shadow is 0000 after reset: EQ not taken, NE taken
    issue(4'h0, 4'b0000); resolve("shadow_rst_eq");
    issue(4'h1, 4'b0000); resolve("shadow_rst_ne");

    // Flag write at count 0 keeps the count at 0 but loads the shadow
    flag_we = 1'b1; flag_nzcv = 4'b0100;
    tick();
    flag_we = 1'b0;
    chk("we_at_zero", {5'd0, pend_cnt}, 8'd0);
    issue(4'h0, 4'b0100);
    resolve("eq_one_cycle");

    // Pending write: branch waits until the writeback arrives
    flag_pend_set = 1'b1;
    tick();
    flag_pend_set = 1'b0;
    chk("pend_one", {5'd0, pend_cnt}, 8'd1);
    issue(4'h1, 4'b0000);
    chk("wait_hold0", {6'd0, res_valid, br_ready}, 8'b00);
    tick();
    chk("wait_hold1", {6'd0, res_valid, br_ready}, 8'b00);
    flag_we = 1'b1; flag_nzcv = 4'b0000;
    tick();
    flag_we = 1'b0;
    resolve("ne_after_wait");

    // Same-cycle request and writeback: flags forwarded
    flag_pend_set = 1'b1;
    tick();
    flag_pend_set = 1'b0;
    flag_we = 1'b1; flag_nzcv = 4'b1001;
    issue(4'hA, 4'b1001);
    flag_we = 1'b0;
    resolve("ge_forward");

    flag_pend_set = 1'b1;
    tick();
    flag_pend_set = 1'b0;
    flag_we = 1'b1; flag_nzcv = 4'b0100;
    issue(4'hC, 4'b0100);
    flag_we = 1'b0;
    resolve("gt_forward");

    // Every condition against two shadow patterns
    flag_we = 1'b1; flag_nzcv = 4'b1010;
    tick();
    flag_we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      issue(c[3:0], 4'b1010);
      resolve("sweep_a");
    end
    flag_we = 1'b1; flag_nzcv = 4'b0111;
    tick();
    flag_we = 1'b0;
    for (int c = 0; c < 16; c++) begin
      issue(c[3:0], 4'b0111);
      resolve("sweep_b");
    end

    // Held response; counting continues while in RESP
    issue(4'h9, 4'b0111);
    for (int i = 0; i < 5; i++) begin
      flag_pend_set = (i == 0);
      chk("hold_valid", {7'd0, res_valid}, 8'd1);
      chk("hold_ready", {7'd0, br_ready}, 8'd0);
      chk("hold_taken", {7'd0, res_taken}, {7'd0, exp_q[0]});
      tick();
    end
    flag_pend_set = 1'b0;
    chk("pend_in_resp", {5'd0, pend_cnt}, 8'd1);
    resolve("hold_release");
    flag_we = 1'b1; flag_nzcv = 4'b0000;
    tick();
    flag_we = 1'b0;
    chk("drain", {5'd0, pend_cnt}, 8'd0);

    // Set and writeback together leave the count alone
    flag_pend_set = 1'b1; flag_we = 1'b1;
    tick();
    flag_pend_set = 1'b0; flag_we = 1'b0;
    chk("both_same", {5'd0, pend_cnt}, 8'd0);

    // Overflow at MAX_PEND=3
    flag_pend_set = 1'b1;
    tick(); tick(); tick();
    chk("ovf_before", {4'd0, err_ovf, pend_cnt}, 8'b0011);
    tick();
    flag_pend_set = 1'b0;
    chk("ovf_cnt", {5'd0, pend_cnt}, 8'd3);
    chk("ovf_flag", {7'd0, err_ovf}, 8'd1);
    flag_we = 1'b1;
    tick(); tick(); tick();
    flag_we = 1'b0;
    chk("ovf_sticky", {4'd0, err_ovf, pend_cnt}, 8'b1000);

    // Reset in the middle of WAIT with two writes pending
    flag_pend_set = 1'b1;
    tick(); tick();
    flag_pend_set = 1'b0;
    chk("pre_rst_pend", {5'd0, pend_cnt}, 8'd2);
    br_valid = 1'b1; br_cond = 4'hE;
    tick();
    br_valid = 1'b0;
    chk("pre_rst_wait", {6'd0, res_valid, br_ready}, 8'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {7'd0, br_ready}, 8'd1);
    chk("mid_rst_valid", {7'd0, res_valid}, 8'd0);
    chk("mid_rst_pend",  {5'd0, pend_cnt}, 8'd0);
    chk("mid_rst_ovf",   {7'd0, err_ovf}, 8'd0);
    chk("mid_rst_taken", {7'd0, res_taken}, 8'd0);
    tick();
    rst_n = 1'b1;
    flag_we = 1'b1; flag_nzcv = 4'b1111;
    tick();
    flag_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_quiet", {6'd0, res_valid, br_ready}, 8'b01);
      tick();
    end
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fb_flag_branch_unit
`default_nettype wire
